cp0_core: RTL and testbench
===========================

// Module: cp0_core
// PURPOSE
//  Parametrised MIPS CP0 register file with timer and interrupt logic, instantiated in the WB stage.
//  Supersedes the fixed CP0: adds Count/Compare timer, timer interrupt, BadVAddr capture,
//  a configurable hardware-interrupt line count and an interrupt request output to the pipeline.
//  Exception/eret/mtc0 commit at WB; mfc0 reads are combinational.
// PARAMETERS
//  NUM_HW_INT  6           hardware interrupt lines used (1..6), mapped to Cause.IP[10+:NUM_HW_INT]
//  COUNT_DIV   2           Count increments once every COUNT_DIV cycles (1..16)
//  ADDR_W      8           CP0 address width, {rd[4:0], sel[2:0]}
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high reset
//  wb_ex        in   1          exception commits this cycle (qualified valid by WB)
//  wb_bd        in   1          excepting instruction is in a delay slot
//  wb_excode    in   5          exception code
//  wb_pc        in   32         PC of excepting instruction
//  wb_badvaddr  in   32         faulting address (AdEL/AdES)
//  eret_flush   in   1          eret commits this cycle
//  ext_int_in   in   NUM_HW_INT hardware interrupt levels, sampled every cycle
//  cp0_addr     in   ADDR_W     mfc0/mtc0 register address
//  mtc0_we      in   1          mtc0 write enable (already gated by !wb_ex)
//  cp0_wdata    in   32         mtc0 write data
//  cp0_rdata    out  32         read data for cp0_addr (combinational)
//  cp0_epc      out  32         EPC value
//  cp0_status   out  32         Status value
//  cp0_cause    out  32         Cause value
//  int_req      out  1          pending enabled interrupt; WB raises exception code 0 on next valid instr
// BEHAVIOUR
//  Registers {rd,sel}: BadVAddr{8,0} Count{9,0} Compare{11,0} Status{12,0} Cause{13,0} EPC{14,0};
//   other addresses read 0, writes ignored.
//  Reset: Status=0x0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0,
//   divider=0; thus cp0_rdata (addr 0)=0, cp0_epc=0, cp0_status=0x0040_0000, cp0_cause=0, int_req=0.
//  Status: BEV[22] RO=1; IM[15:8] RW; EXL[1] RW; IE[0] RW; other bits RO 0.
//  Cause: BD[31] RO; TI[30] RO; IP[15:10] RO; IP[9:8] RW; ExcCode[6:2] RO; other bits 0.
//  IP[10+i]=ext_int_in[i] registered each cycle, i<NUM_HW_INT; unused IP bits 0; IP[15] |= TI.
//  wb_ex: Status.EXL<=1, Cause.ExcCode<=wb_excode; if EXL was 0: EPC<=wb_bd?wb_pc-4:wb_pc,
//   Cause.BD<=wb_bd; if EXL was 1, EPC and BD unchanged. ExcCode 4/5: BadVAddr<=wb_badvaddr.
//  eret_flush: Status.EXL<=0. Priority same cycle: wb_ex > eret_flush > mtc0 on EXL.
//  mtc0 to EPC/BadVAddr/Status/Cause fields: takes effect next cycle; wb_ex overrides same-field writes.
//  Timer: divider counts 0..COUNT_DIV-1, Count+=1 (mod 2^32, wraps) when divider=COUNT_DIV-1.
//   mtc0 Count: Count<=wdata, divider<=0, no increment that cycle.
//   mtc0 Compare: Compare<=wdata, TI<=0 (clear wins over set that cycle).
//   TI<=1 when Count==Compare and Compare not written this cycle; sticky until Compare written.
//  int_req = Status.IE & !Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]); combinational from regs.
//  cp0_rdata reflects register state before this cycle's writes (no write-through).
//  Reset mid-operation returns all state to reset values in one cycle; pending TI lost.
// TESTING
//  reset, read addr {12,0} -> 0x0040_0000; {13,0} -> 0; int_req=0.
//  wb_ex, excode=0x08, pc=0xBFC0_0100, bd=1 -> EPC=0xBFC0_00FC, Cause=0x8000_0020, EXL=1; 2nd wb_ex pc=0x100 -> EPC unchanged.
//  COUNT_DIV=2: mtc0 Compare=5, Count=3 -> TI=1 five cycles later, int_req=1 once Status=0x0000_8001; mtc0 Compare -> TI=0.
//  mtc0 Count=0xFFFF_FFFF -> Count wraps to 0 after COUNT_DIV cycles.
//  ext_int_in[2]=1, IM[12]=1, IE=1, EXL=0 -> Cause.IP[12]=1 next cycle, int_req=1; EXL=1 -> int_req=0.
//  wb_ex excode=4 badvaddr=0x8000_0003 + same-cycle eret -> BadVAddr=0x8000_0003, EXL=1.

Source files
------------

// File: rtl/cp0_core.sv
// MIPS CP0 register file for the WB stage: Status/Cause/EPC/BadVAddr, a Count/Compare timer and interrupt request.
// Exception, eret and mtc0 updates commit on the clock edge; mfc0 reads are combinational from current state.
module cp0_core #(
  parameter int NUM_HW_INT = 6,
  parameter int COUNT_DIV  = 2,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_ex,
  input  logic                  wb_bd,
  input  logic [4:0]            wb_excode,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_badvaddr,
  input  logic                  eret_flush,
  input  logic [NUM_HW_INT-1:0] ext_int_in,
  input  logic [ADDR_W-1:0]     cp0_addr,
  input  logic                  mtc0_we,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  output logic [31:0]           cp0_epc,
  output logic [31:0]           cp0_status,
  output logic [31:0]           cp0_cause,
  output logic                  int_req
);

  localparam logic [ADDR_W-1:0] A_BADVADDR = ADDR_W'({5'd8,  3'd0});
  localparam logic [ADDR_W-1:0] A_COUNT    = ADDR_W'({5'd9,  3'd0});
  localparam logic [ADDR_W-1:0] A_COMPARE  = ADDR_W'({5'd11, 3'd0});
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'({5'd12, 3'd0});
  localparam logic [ADDR_W-1:0] A_CAUSE    = ADDR_W'({5'd13, 3'd0});
  localparam logic [ADDR_W-1:0] A_EPC      = ADDR_W'({5'd14, 3'd0});
  localparam logic [3:0]        DIV_MAX    = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d;
  logic [31:0] compare_q, compare_d, epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  excode_q, excode_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  ip_val;
  logic        wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_badvaddr = mtc0_we && (cp0_addr == A_BADVADDR);
  assign wr_count    = mtc0_we && (cp0_addr == A_COUNT);
  assign wr_compare  = mtc0_we && (cp0_addr == A_COMPARE);
  assign wr_status   = mtc0_we && (cp0_addr == A_STATUS);
  assign wr_cause    = mtc0_we && (cp0_addr == A_CAUSE);
  assign wr_epc      = mtc0_we && (cp0_addr == A_EPC);

  // Timer interrupt shares the top IP line with the last hardware interrupt.
  assign ip_val     = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign cp0_status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti_q, 14'd0, ip_val, 1'b0, excode_q, 2'b00};
  assign cp0_epc    = epc_q;
  assign int_req    = ie_q & ~exl_q & (|(ip_val & im_q));

  always_comb begin
    case (cp0_addr)
      A_BADVADDR: cp0_rdata = badvaddr_q;
      A_COUNT:    cp0_rdata = count_q;
      A_COMPARE:  cp0_rdata = compare_q;
      A_STATUS:   cp0_rdata = cp0_status;
      A_CAUSE:    cp0_rdata = cp0_cause;
      A_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    excode_d   = excode_q;
    div_d      = div_q;
    ip_hw_d    = 6'(ext_int_in);

    if (wr_badvaddr) badvaddr_d = cp0_wdata;
    if (wr_epc)      epc_d      = cp0_wdata;
    if (wr_compare)  compare_d  = cp0_wdata;
    if (wr_cause)    ip_sw_d    = cp0_wdata[9:8];
    if (wr_status) begin
      im_d  = cp0_wdata[15:8];
      exl_d = cp0_wdata[1];
      ie_d  = cp0_wdata[0];
    end

    if (wr_count) begin
      count_d = cp0_wdata;
      div_d   = 4'd0;
    end else if (div_q == DIV_MAX) begin
      count_d = count_q + 32'd1;
      div_d   = 4'd0;
    end else begin
      div_d = div_q + 4'd1;
    end

    if (wr_compare)                 ti_d = 1'b0;
    else if (count_q == compare_q)  ti_d = 1'b1;

    // Later assignments win: exception over eret over mtc0.
    if (eret_flush) exl_d = 1'b0;
    if (wb_ex) begin
      exl_d    = 1'b1;
      excode_d = wb_excode;
      if (!exl_q) begin
        epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
        bd_d  = wb_bd;
      end
      if (wb_excode == 5'd4 || wb_excode == 5'd5) badvaddr_d = wb_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      excode_q   <= 5'd0;
      div_q      <= 4'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      excode_q   <= excode_d;
      div_q      <= div_d;
    end
  end

endmodule

// File: tb/tb_cp0_core.sv
// Bench for cp0_core: one-cycle vectors from a table, expected read-back queued at drive time and
// popped after the edge; hand-written sequences cover reset, no write-through and mid-run reset.
module tb_cp0_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex, wb_bd, eret_flush, mtc0_we, int_req;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata, cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic [5:0]  ext_int_in;
  logic [7:0]  cp0_addr;

  always #5 clk = ~clk;

  cp0_core #(.NUM_HW_INT(6), .COUNT_DIV(2), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .ext_int_in(ext_int_in),
    .cp0_addr(cp0_addr), .mtc0_we(mtc0_we), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .cp0_epc(cp0_epc), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .int_req(int_req)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        ex;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        eret;
    logic [5:0]  ext;
    logic [7:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        intr;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [7:0] BADV = 8'h40, CNT = 8'h48, CMP = 8'h58, STS = 8'h60, CAU = 8'h68, EPC = 8'h70;

  function automatic vec_t mk(logic we, logic [7:0] wa, logic [31:0] wd, logic ex, logic bd,
                              logic [4:0] code, logic [31:0] pc, logic [31:0] badv, logic eret,
                              logic [5:0] ext, logic [7:0] ra, logic [31:0] erd, logic eint);
    vec_t v;
    v = '{we, wa, wd, ex, bd, code, pc, badv, eret, ext, ra, erd, eint};
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mtc0_we = 1'b0; wb_ex = 1'b0; wb_bd = 1'b0; eret_flush = 1'b0;
    wb_excode = 5'd0; wb_pc = 32'd0; wb_badvaddr = 32'd0; cp0_wdata = 32'd0;
  endtask

  initial begin
    sb_t e;
    //          we  waddr wdata          ex bd code   pc            badv           er ext       raddr exp_rd         int
    tbl.push_back(mk(1, CMP,  32'h0000_1000, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CMP,  32'h0000_1000, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         1, 1, 5'h08, 32'hBFC0_0100, 32'h0,        0, 6'b000000, EPC,  32'hBFC0_00FC, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0020, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         1, 0, 5'h0C, 32'h0000_0100, 32'h0,        0, 6'b000000, EPC,  32'hBFC0_00FC, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, STS,  32'h0040_0002, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         1, 6'b000000, STS,  32'h0040_0000, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0030, 0));
    tbl.push_back(mk(1, CMP,  32'd5,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0030, 0));
    tbl.push_back(mk(1, CNT,  32'd3,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'd3,         0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'd3,         0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'd4,         0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'd4,         0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'd5,         0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'hC000_8030, 0));
    tbl.push_back(mk(1, STS,  32'h0000_8001, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, STS,  32'h0040_8001, 1));
    tbl.push_back(mk(1, CMP,  32'h0000_0100, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0030, 0));
    tbl.push_back(mk(1, CNT,  32'hFFFF_FFFF, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CNT,  32'h0000_0000, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000100, CAU,  32'h8000_1030, 0));
    tbl.push_back(mk(1, STS,  32'h0000_1001, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000100, STS,  32'h0040_1001, 1));
    tbl.push_back(mk(1, STS,  32'h0000_1003, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000100, STS,  32'h0040_1003, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         1, 6'b000000, CAU,  32'h8000_0030, 0));
    tbl.push_back(mk(1, CAU,  32'hFFFF_FFFF, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0330, 0));
    tbl.push_back(mk(1, STS,  32'h0000_0201, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, STS,  32'h0040_0201, 1));
    tbl.push_back(mk(1, CAU,  32'h0000_0000, 0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h8000_0030, 0));
    tbl.push_back(mk(1, 8'h08, 32'hDEAD_BEEF, 0, 0, 5'd0, 32'h0,        32'h0,         0, 6'b000000, 8'h08, 32'h0,        0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         1, 0, 5'd4,  32'h0000_2000, 32'h8000_0003, 1, 6'b000000, BADV, 32'h8000_0003, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, STS,  32'h0040_0203, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h0000_0010, 0));
    tbl.push_back(mk(1, BADV, 32'h0000_1111, 1, 1, 5'd5,  32'h0000_3000, 32'h0000_2222, 0, 6'b000000, BADV, 32'h0000_2222, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, CAU,  32'h0000_0014, 0));
    tbl.push_back(mk(0, 8'h0, 32'h0,         0, 0, 5'd0,  32'h0,        32'h0,         0, 6'b000000, EPC,  32'h0000_2000, 0));

    reset = 1'b1;
    idle_inputs();
    ext_int_in = 6'd0;
    cp0_addr   = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata addr0", cp0_rdata, 32'h0);
    chk("reset cp0_status", cp0_status, 32'h0040_0000);
    chk("reset cp0_cause", cp0_cause, 32'h0);
    chk("reset cp0_epc", cp0_epc, 32'h0);
    chk("reset int_req", 32'(int_req), 32'h0);
    cp0_addr = STS; #1;
    chk("reset read status", cp0_rdata, 32'h0040_0000);
    cp0_addr = CAU; #1;
    chk("reset read cause", cp0_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      mtc0_we     = tbl[i].we;
      cp0_addr    = tbl[i].we ? tbl[i].waddr : tbl[i].raddr;
      cp0_wdata   = tbl[i].wdata;
      wb_ex       = tbl[i].ex;
      wb_bd       = tbl[i].bd;
      wb_excode   = tbl[i].code;
      wb_pc       = tbl[i].pc;
      wb_badvaddr = tbl[i].badv;
      eret_flush  = tbl[i].eret;
      ext_int_in  = tbl[i].ext;
      sb.push_back('{i, tbl[i].exp_rd, tbl[i].exp_int});
      @(posedge clk);
      #1;
      idle_inputs();
      cp0_addr = tbl[i].raddr;
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d rdata", e.idx), cp0_rdata, e.rd);
      chk($sformatf("vec%0d int_req", e.idx), 32'(int_req), 32'(e.intr));
      @(negedge clk);
    end

    // Read during an mtc0 cycle must still show the old EPC.
    cp0_addr  = EPC;
    mtc0_we   = 1'b1;
    cp0_wdata = 32'h1234_5678;
    #1;
    chk("no write-through epc", cp0_rdata, 32'h0000_2000);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("mtc0 epc visible", cp0_epc, 32'h1234_5678);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset status", cp0_status, 32'h0040_0000);
    chk("mid reset cause", cp0_cause, 32'h0);
    chk("mid reset epc", cp0_epc, 32'h0);
    chk("mid reset int_req", 32'(int_req), 32'h0);
    cp0_addr = CNT; #1;
    chk("mid reset count", cp0_rdata, 32'h0);
    cp0_addr = BADV; #1;
    chk("mid reset badvaddr", cp0_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
